// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe
// Purpose  : Two-stage pipelined ALU using MIPS funct encoding. It has a
//            valid/ready handshake on both sides, registered status flags
//            and illegal-opcode detection.
//            Stage 1 registers the operands and the operation code.
//            Stage 2 computes the result and registers it together with the
//            zero, ovf and illegal_op flags.
// Ports    : clk, rst_n             - clock; asynchronous active-low reset
//            in_valid / in_ready    - upstream handshake
//            dataA, dataB           - operands (dataB is also the shift amount)
//            operation              - function code
//            out_valid / out_ready  - downstream handshake
//            result                 - DATA_W+1 bits; top bit is carry/borrow
//            zero, ovf, illegal_op  - status flags for result
// Options  : ALU_PIPE_SAT_EN - when defined, ADD/SUB saturate to the signed
//            limits on overflow. The build is complete without it.
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int DATA_W = 7,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    input  logic [OP_W-1:0]   operation,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W:0]   result,
    output logic              zero,
    output logic              ovf,
    output logic              illegal_op
);

    localparam logic [OP_W-1:0] c_op_add = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] c_op_sub = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] c_op_and = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] c_op_or  = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] c_op_xor = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] c_op_nor = OP_W'(6'b100111);
    localparam logic [OP_W-1:0] c_op_sll = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] c_op_srl = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] c_op_sra = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] c_op_slt = OP_W'(6'b101010);

    // Shift amounts at or above this value shift every bit out.
    localparam logic [DATA_W-1:0] c_shift_lim = DATA_W'(DATA_W);
    localparam int                c_msb       = DATA_W - 1;

    // Stage 1 registers
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [OP_W-1:0]   r_s1_op;

    // Stage 2 registers. These drive the outputs directly.
    logic              r_s2_valid;
    logic [DATA_W:0]   r_result;
    logic              r_zero;
    logic              r_ovf;
    logic              r_illegal;

    // Handshake and compute wires
    logic              w_s2_load;
    logic              w_s1_load;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic [DATA_W-1:0] w_sra;
    logic              w_shift_big;
    logic              w_lt;
    logic [DATA_W:0]   w_res;
    logic              w_ovf;
    logic              w_illegal;
    logic              w_zero;

    // Stage 2 advances whenever its slot is empty or is being drained.
    // Stage 1 advances whenever stage 2 takes its contents or it is empty.
    // This allows a push and a pop on the same cycle at a full pipe, so no
    // bubble is inserted.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= dataA;
                r_s1_b  <= dataB;
                r_s1_op <= operation;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational ALU
    // ------------------------------------------------------------------
    always_comb begin
        // Zero-extend the operands so that the top bit of the sum is the
        // carry. For the difference, the top bit is the borrow (A < B unsigned).
        w_sum       = {1'b0, r_s1_a} + {1'b0, r_s1_b};
        w_diff      = {1'b0, r_s1_a} - {1'b0, r_s1_b};
        w_sra       = $signed(r_s1_a) >>> r_s1_b;
        w_shift_big = (r_s1_b >= c_shift_lim);
        w_lt        = ($signed(r_s1_a) < $signed(r_s1_b));
        w_res       = '0;
        w_ovf       = 1'b0;
        w_illegal   = 1'b0;

        case (r_s1_op)
            c_op_add: begin
                w_res = w_sum;
                w_ovf = (r_s1_a[c_msb] == r_s1_b[c_msb]) &&
                        (w_sum[c_msb] != r_s1_a[c_msb]);
            end
            c_op_sub: begin
                w_res = w_diff;
                w_ovf = (r_s1_a[c_msb] != r_s1_b[c_msb]) &&
                        (w_diff[c_msb] != r_s1_a[c_msb]);
            end
            c_op_and: w_res = {1'b0, r_s1_a & r_s1_b};
            c_op_or:  w_res = {1'b0, r_s1_a | r_s1_b};
            c_op_xor: w_res = {1'b0, r_s1_a ^ r_s1_b};
            c_op_nor: w_res = {1'b0, ~(r_s1_a | r_s1_b)};
            c_op_sll: w_res = w_shift_big ? '0 : {1'b0, r_s1_a << r_s1_b};
            c_op_srl: w_res = w_shift_big ? '0 : {1'b0, r_s1_a >> r_s1_b};
            c_op_sra: w_res = w_shift_big ? {1'b0, {DATA_W{r_s1_a[c_msb]}}}
                                          : {1'b0, w_sra};
            c_op_slt: w_res = {{DATA_W{1'b0}}, w_lt};
            default: begin
                w_res     = '0;
                w_illegal = 1'b1;
            end
        endcase

`ifdef ALU_PIPE_SAT_EN
        // Only ADD and SUB can raise w_ovf. In both cases the sign of A gives
        // the overflow direction. The carry/borrow bit keeps its raw value.
        if (w_ovf) begin
            w_res[DATA_W-1:0] = r_s1_a[c_msb] ? {1'b1, {(DATA_W-1){1'b0}}}
                                              : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif

        // An illegal opcode forces the result to zero, so zero reads 1.
        w_zero = (w_res[DATA_W-1:0] == '0);
    end

    // ------------------------------------------------------------------
    // Stage 2: result register. The result and flags hold while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result  <= w_res;
                r_zero    <= w_zero;
                r_ovf     <= w_ovf;
                r_illegal <= w_illegal;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign result     = r_result;
    assign zero       = r_zero;
    assign ovf        = r_ovf;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Directed testbench for alu_pipe with DATA_W=7 and OP_W=6.
//            Covers reset, streaming, arithmetic and flag results, shifts,
//            illegal codes, back-pressure and reset mid-stream.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_pipe;

    localparam int DATA_W = 7;
    localparam int OP_W   = 6;

    localparam logic [5:0] c_add = 6'b100000;
    localparam logic [5:0] c_sub = 6'b100010;
    localparam logic [5:0] c_and = 6'b100100;
    localparam logic [5:0] c_or  = 6'b100101;
    localparam logic [5:0] c_xor = 6'b100110;
    localparam logic [5:0] c_nor = 6'b100111;
    localparam logic [5:0] c_sll = 6'b000000;
    localparam logic [5:0] c_srl = 6'b000010;
    localparam logic [5:0] c_sra = 6'b000011;
    localparam logic [5:0] c_slt = 6'b101010;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] dataA;
    logic [DATA_W-1:0] dataB;
    logic [OP_W-1:0]   operation;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   result;
    logic              zero;
    logic              ovf;
    logic              illegal_op;

    int vectors     = 0;
    int miscompares = 0;
    int ntx;
    int nrx;

    logic [6:0] bp_a   [4] = '{7'd1, 7'd2, 7'd3, 7'd4};
    logic [7:0] bp_exp [4] = '{8'h02, 8'h04, 8'h06, 8'h08};

    alu_pipe #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dataA      (dataA),
        .dataB      (dataB),
        .operation  (operation),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .ovf        (ovf),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] a, input logic [6:0] b, input logic [5:0] op);
        in_valid  = 1'b1;
        dataA     = a;
        dataB     = b;
        operation = op;
    endtask

    // Issue one transaction with out_ready=1 and check it two edges later.
    task automatic single(input string tag, input logic [6:0] a, input logic [6:0] b,
                          input logic [5:0] op, input logic [7:0] e_res,
                          input logic e_z, input logic e_o, input logic e_il);
        drive(a, b, op);
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, {24'd0, result}, {24'd0, e_res});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, e_z});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e_o});
        check({tag, "_illegal"}, {31'd0, illegal_op}, {31'd0, e_il});
        tick();
    endtask

    initial begin
        // Reset is held with in_valid asserted.
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(7'h12, 7'h34, c_add);
        tick();
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_illegal", {31'd0, illegal_op}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        check("post_rst_idle", {31'd0, out_valid}, 32'd0);

        // Streaming: SRL, then ADD on the next cycle with no bubble.
        drive(7'b0000111, 7'b0000010, c_srl);
        tick();
        drive(7'b0000111, 7'b0000010, c_add);
        tick();
        in_valid = 1'b0;
        check("stream_srl_valid", {31'd0, out_valid}, 32'd1);
        check("stream_srl", {24'd0, result}, 32'h01);
        tick();
        check("stream_add_valid", {31'd0, out_valid}, 32'd1);
        check("stream_add", {24'd0, result}, 32'h09);
        tick();
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Arithmetic and flags
        single("add_carry", 7'h7F, 7'h01, c_add, 8'h80, 1'b1, 1'b0, 1'b0);
`ifdef ALU_PIPE_SAT_EN
        single("add_ovf", 7'h3F, 7'h01, c_add, 8'h3F, 1'b0, 1'b1, 1'b0);
        single("sub_ovf", 7'h40, 7'h01, c_sub, 8'h40, 1'b0, 1'b1, 1'b0);
`else
        single("add_ovf", 7'h3F, 7'h01, c_add, 8'h40, 1'b0, 1'b1, 1'b0);
        single("sub_ovf", 7'h40, 7'h01, c_sub, 8'h3F, 1'b0, 1'b1, 1'b0);
`endif
        single("sub_borrow", 7'h02, 7'h05, c_sub, 8'hFD, 1'b0, 1'b0, 1'b0);
        single("slt", 7'h7F, 7'h01, c_slt, 8'h01, 1'b0, 1'b0, 1'b0);
        single("and", 7'h55, 7'h33, c_and, 8'h11, 1'b0, 1'b0, 1'b0);
        single("or", 7'h55, 7'h33, c_or, 8'h77, 1'b0, 1'b0, 1'b0);
        single("xor", 7'h55, 7'h33, c_xor, 8'h66, 1'b0, 1'b0, 1'b0);
        single("nor", 7'h55, 7'h33, c_nor, 8'h08, 1'b0, 1'b0, 1'b0);
        single("sra_big", 7'h40, 7'd9, c_sra, 8'h7F, 1'b0, 1'b0, 1'b0);
        single("sra_3", 7'h48, 7'd3, c_sra, 8'h79, 1'b0, 1'b0, 1'b0);
        single("sll_out", 7'h01, 7'd7, c_sll, 8'h00, 1'b1, 1'b0, 1'b0);
        single("sll_2", 7'h13, 7'd2, c_sll, 8'h4C, 1'b0, 1'b0, 1'b0);
        single("illegal", 7'h55, 7'h33, 6'b111111, 8'h00, 1'b1, 1'b0, 1'b1);

        // Back-pressure: out_ready low for 5 cycles while 4 items are offered.
        out_ready = 1'b0;
        ntx = 0;
        drive(bp_a[0], bp_a[0], c_add);
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (in_valid && in_ready) ntx++;
            tick();
            if (ntx < 4) drive(bp_a[ntx], bp_a[ntx], c_add);
            else in_valid = 1'b0;
            if (cyc == 2) check("bp_hold_early", {24'd0, result}, 32'h02);
        end
        check("bp_accepted", ntx, 32'd2);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_late", {24'd0, result}, 32'h02);

        // Release: a pop and a push happen on the same edge at a full pipe.
        out_ready = 1'b1;
        #1;
        check("bp_push_pop", {31'd0, in_ready}, 32'd1);
        nrx = 0;
        for (int cyc = 0; cyc < 20 && nrx < 4; cyc++) begin
            if (out_valid) begin
                check("bp_order", {24'd0, result}, {24'd0, bp_exp[nrx]});
                nrx++;
            end
            if (in_valid && in_ready) ntx++;
            tick();
            if (ntx < 4) drive(bp_a[ntx], bp_a[ntx], c_add);
            else in_valid = 1'b0;
        end
        check("bp_received", nrx, 32'd4);
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream with two items in flight.
        drive(7'h01, 7'h02, c_add);
        tick();
        drive(7'h03, 7'h04, c_add);
        tick();
        in_valid = 1'b0;
        check("midrst_inflight", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", {24'd0, result}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            check("midrst_no_output", {31'd0, out_valid}, 32'd0);
        end
        single("after_rst", 7'h05, 7'h07, c_sub, 8'hFE, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
